// File: rtl/tff_arb_pkg.sv
// Shared types and helpers for the toggle-bank arbiter: FSM state encoding,
// index sizing and the round-robin winner search.
package tff_arb_pkg;

  // Indices are sized for the largest supported requester count.
  // Unused upper entries are tied off in the top level.
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

  // First set bit of req at or after ptr, wrapping modulo n.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input int unsigned        n
  );
    int unsigned cand;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= n) cand = cand - n;
      if (!found && (k < n) && req[cand[IDX_W-1:0]]) begin
        rr_pick = cand[IDX_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop with synchronous active-high reset (Q=0, QN=1).
module tff_cell (
  input  logic CLK,
  input  logic RST,
  input  logic t_i,
  output logic q_o,
  output logic qn_o
);

  logic q_q;

  always_ff @(posedge CLK) begin
    if (RST)      q_q <= 1'b0;
    else if (t_i) q_q <= ~q_q;
  end

  assign q_o  = q_q;
  assign qn_o = ~q_q;

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter granting one requester at a time the right to toggle
// the shared flag bank with its mask for a single cycle, via four-phase REQ/ACK.
module tff_toggle_arbiter
  import tff_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] MASK,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       ACK,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH-1:0]       QN,
  output logic                   BUSY
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   mask_q, mask_d;

  logic [MAX_REQ-1:0] req_pad;
  logic [IDX_W-1:0]   winner;
  logic [WIDTH-1:0]   mask_arr [MAX_REQ];
  logic [MAX_REQ-1:0] onehot;
  logic [WIDTH-1:0]   t_vec;

  assign req_pad = MAX_REQ'(REQ);
  assign winner  = rr_pick(req_pad, ptr_q, N_REQ);

  // Unpack MASK so the winner index selects a slice directly.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_REQ; gi++) begin : g_mask
      if (gi < N_REQ) begin : g_used
        assign mask_arr[gi] = MASK[gi*WIDTH +: WIDTH];
      end else begin : g_unused
        assign mask_arr[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          idx_d   = winner;
          mask_d  = mask_arr[winner];
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: state_d = ST_ACK;
      ST_ACK: begin
        if (!req_pad[idx_q]) begin
          state_d = ST_IDLE;
          ptr_d   = (32'(idx_q) == N_REQ - 1) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode only registered state, so REQ/MASK never reach them combinationally.
  always_comb begin
    onehot = MAX_REQ'(1) << idx_q;
    GNT    = '0;
    ACK    = '0;
    BUSY   = (state_q != ST_IDLE);
    t_vec  = (state_q == ST_APPLY) ? mask_q : '0;
    if (state_q != ST_IDLE) GNT = onehot[N_REQ-1:0];
    if (state_q == ST_ACK)  ACK = onehot[N_REQ-1:0];
  end

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bank
      tff_cell u_cell (
        .CLK  (CLK),
        .RST  (RST),
        .t_i  (t_vec[gi]),
        .q_o  (Q[gi]),
        .qn_o (QN[gi])
      );
    end
  endgenerate

endmodule
